// File: rtl/vid_seq.sv
// vid.v command sequencer: splits one command into tail-masked index beats and
// counts results in flight. Optional vstart support under VID_SEQ_VSTART_EN.
module vid_seq #(
  parameter int unsigned REQ_DATA_WIDTH    = 64,
  parameter int unsigned REQ_BYTE_EN_WIDTH = 8,
  parameter int unsigned REQ_ADDR_WIDTH    = 5,
  parameter int unsigned VL_WIDTH          = 12,
  parameter int unsigned NUM_STAGES        = 6,
  parameter int unsigned ENABLE_64_BIT     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [1:0]                   cmd_sew,
  input  logic [VL_WIDTH-1:0]          cmd_vl,
`ifdef VID_SEQ_VSTART_EN
  input  logic [VL_WIDTH-1:0]          cmd_vstart,
`endif
  input  logic                         issue_ready,
  output logic                         id_valid,
  output logic [REQ_ADDR_WIDTH-1:0]    id_addr,
  output logic [1:0]                   id_sew,
  output logic [VL_WIDTH-1:0]          id_start_idx,
  output logic [REQ_BYTE_EN_WIDTH-1:0] id_be,
  input  logic                         resp_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned NumBytes = REQ_DATA_WIDTH / 8;
  localparam int unsigned EpbLog   = $clog2(REQ_BYTE_EN_WIDTH);
  localparam int unsigned OutW     = $clog2(NUM_STAGES + 1) + 1;
  localparam int unsigned ElemW    = VL_WIDTH + 1;
  localparam logic [OutW-1:0]     OutMax = {OutW{1'b1}};
  localparam logic [OutW-1:0]     OutOne = 1;
  localparam logic [VL_WIDTH-1:0] VlOne  = 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                      state_q, state_d;
  logic [REQ_ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]                  sew_q;
  logic [VL_WIDTH-1:0]         vl_q, vstart_q, beat_q;
  logic [OutW-1:0]             out_q, out_d;
  logic                        err_q;

  logic [VL_WIDTH-1:0]         cmd_vstart_int, first_beat, last_beat, start_idx;
  logic [7:0]                  cmd_shamt, shamt;
  logic [ElemW-1:0]            elem;
  logic                        cmd_sew_bad, cmd_empty, accept, issuing, fire, dec;

`ifdef VID_SEQ_VSTART_EN
  assign cmd_vstart_int = cmd_vstart;
`else
  assign cmd_vstart_int = '0;
`endif

  // log2(elements per beat); beat math is shift-only.
  assign cmd_shamt   = 8'(EpbLog) - {6'b0, cmd_sew};
  assign shamt       = 8'(EpbLog) - {6'b0, sew_q};
  assign cmd_sew_bad = (ENABLE_64_BIT == 0) && (cmd_sew == 2'b11);
  assign cmd_empty   = cmd_sew_bad || (cmd_vstart_int >= cmd_vl);
  assign first_beat  = cmd_vstart_int >> cmd_shamt;
  assign last_beat   = (vl_q - VlOne) >> shamt;
  assign start_idx   = beat_q << shamt;

  assign accept  = (state_q == StIdle) && cmd_valid;
  assign issuing = (state_q == StIssue);
  assign fire    = issuing && issue_ready;
  assign dec     = resp_valid && (state_q != StIdle);

  assign id_valid     = issuing;
  assign id_addr      = issuing ? addr_q + REQ_ADDR_WIDTH'(beat_q) : '0;
  assign id_sew       = issuing ? sew_q : '0;
  assign id_start_idx = issuing ? start_idx : '0;

  // Enable a byte only if its element lies in [vstart, vl).
  always_comb begin
    id_be = '0;
    elem  = '0;
    if (issuing) begin
      for (int b = 0; b < NumBytes; b++) begin
        elem     = {1'b0, start_idx} + ElemW'(b >> sew_q);
        id_be[b] = (elem < {1'b0, vl_q}) && (elem >= {1'b0, vstart_q});
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (accept) begin
      out_d = '0;
    end else if (fire && !dec) begin
      if (out_q != OutMax) out_d = out_q + OutOne;
    end else if (dec && !fire) begin
      if (out_q != '0) out_d = out_q - OutOne;
    end
  end

  // Empty or illegal commands pass through DRAIN with nothing outstanding.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = cmd_empty ? StDrain : StIssue;
      end
      StIssue: begin
        if (issue_ready && (beat_q == last_beat)) state_d = StDrain;
      end
      StDrain: begin
        if (out_d == '0) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      sew_q    <= '0;
      vl_q     <= '0;
      vstart_q <= '0;
      beat_q   <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (accept) begin
        addr_q   <= cmd_addr;
        sew_q    <= cmd_sew;
        vl_q     <= cmd_vl;
        vstart_q <= cmd_vstart_int;
        beat_q   <= first_beat;
        err_q    <= cmd_sew_bad;
      end else if (fire) begin
        beat_q <= beat_q + VlOne;
      end
    end
  end

endmodule

// File: tb/tb_vid_seq.sv
// Scoreboard bench for vid_seq: driver queues expected beats/dones, a negedge
// monitor pops and compares. Exercises the vstart path when VID_SEQ_VSTART_EN is set.
module tb_vid_seq;
  localparam int AW = 5;
  localparam int VW = 12;
  localparam int BW = 8;
  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_sew;
  logic [VW-1:0] cmd_vl;
  logic [VW-1:0] cmd_vstart;
  logic          issue_ready, id_valid;
  logic [AW-1:0] id_addr;
  logic [1:0]    id_sew;
  logic [VW-1:0] id_start_idx;
  logic [BW-1:0] id_be;
  logic          resp_valid, busy, done, err;
  logic [NS-1:0] pipe;

  vid_seq #(
    .REQ_DATA_WIDTH   (64),
    .REQ_BYTE_EN_WIDTH(BW),
    .REQ_ADDR_WIDTH   (AW),
    .VL_WIDTH         (VW),
    .NUM_STAGES       (NS),
    .ENABLE_64_BIT    (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_sew     (cmd_sew),
    .cmd_vl      (cmd_vl),
`ifdef VID_SEQ_VSTART_EN
    .cmd_vstart  (cmd_vstart),
`endif
    .issue_ready (issue_ready),
    .id_valid    (id_valid),
    .id_addr     (id_addr),
    .id_sew      (id_sew),
    .id_start_idx(id_start_idx),
    .id_be       (id_be),
    .resp_valid  (resp_valid),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Downstream index pipeline: a transferred beat returns NS cycles later.
  always @(posedge clk) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[NS-2:0], id_valid && issue_ready};
  end
  assign resp_valid = pipe[NS-1];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    sew;
    logic [VW-1:0] start;
    logic [BW-1:0] be;
  } beat_t;

  typedef struct packed {
    logic       err;
    logic [7:0] lat;
  } done_t;

  beat_t beat_exp[$];
  done_t done_exp[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    done_seen = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  beat_t got, hold;
  done_t dgot;
  logic  stalled = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_beat(input logic [AW-1:0] a, input logic [1:0] s, input logic [VW-1:0] st,
                          input logic [BW-1:0] be);
    beat_t b;
    b.addr = a; b.sew = s; b.start = st; b.be = be;
    beat_exp.push_back(b);
  endtask

  task automatic exp_done(input logic e, input logic [7:0] lat);
    done_t d;
    d.err = e; d.lat = lat;
    done_exp.push_back(d);
  endtask

  // Monitor: latency is measured in cycles from the accept cycle to the done cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      got = {id_addr, id_sew, id_start_idx, id_be};
      if (stalled && id_valid) check("stall_hold", got, hold);
      stalled = id_valid && !issue_ready;
      hold    = got;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (id_valid && issue_ready) begin
        if (beat_exp.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", got);
        end else begin
          check("beat", got, beat_exp.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        if (done_exp.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done err=%0b, expected no done", err);
        end else begin
          dgot = done_exp.pop_front();
          check("done_err", err, dgot.err);
          check("done_latency", 64'(cyc - acc_cyc), dgot.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [1:0] s, input logic [VW-1:0] v,
                      input logic [7:0] rdy, input int rlen);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1");
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_sew   = s;
    cmd_vl    = v;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < rlen; i++) begin
      issue_ready = rdy[i];
      tick();
    end
    issue_ready = 1'b1;
  endtask

  task automatic wait_done(input int target, input string name);
    int guard = 0;
    while (done_seen < target && guard < 60) begin
      tick();
      guard++;
    end
    if (done_seen < target) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done, expected done", name);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_rst;
    exp_rst     = 32'h8000_0000;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_sew     = '0;
    cmd_vl      = '0;
    cmd_vstart  = '0;
    issue_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", {cmd_ready, id_valid, id_addr, id_sew, id_start_idx, id_be, busy,
                            done, err}, exp_rst);
    rst_n = 1'b1;
    tick();

    exp_beat(5'd3, 2'd0, 12'd0, 8'hFF);
    exp_beat(5'd4, 2'd0, 12'd8, 8'hFF);
    exp_beat(5'd5, 2'd0, 12'd16, 8'h0F);
    exp_done(1'b0, 8'd10);
    send(5'd3, 2'd0, 12'd20, 8'h00, 0);
    wait_done(1, "sew8_vl20");

    exp_beat(5'd7, 2'd2, 12'd0, 8'hFF);
    exp_beat(5'd8, 2'd2, 12'd2, 8'hFF);
    exp_done(1'b0, 8'd11);
    send(5'd7, 2'd2, 12'd4, 8'b0000_1001, 4);
    wait_done(2, "stall");

    exp_done(1'b0, 8'd2);
    send(5'd1, 2'd0, 12'd0, 8'h00, 0);
    wait_done(3, "vl0");

    exp_done(1'b1, 8'd2);
    send(5'd2, 2'd3, 12'd8, 8'h00, 0);
    wait_done(4, "sew64_illegal");

    exp_beat(5'd30, 2'd1, 12'd0, 8'hFF);
    exp_beat(5'd31, 2'd1, 12'd4, 8'hFF);
    exp_beat(5'd0,  2'd1, 12'd8, 8'hFF);
    exp_done(1'b0, 8'd10);
    send(5'd30, 2'd1, 12'd12, 8'h00, 0);
    wait_done(5, "addr_wrap");

    exp_beat(5'd0, 2'd1, 12'd0, 8'h3F);
    exp_done(1'b0, 8'd8);
    send(5'd0, 2'd1, 12'd3, 8'h00, 0);
    wait_done(6, "sew16_tail");

    // Reset right after the first beat of a three-beat command.
    exp_beat(5'd3, 2'd0, 12'd0, 8'hFF);
    send(5'd3, 2'd0, 12'd20, 8'h01, 1);
    rst_n       = 1'b0;
    issue_ready = 1'b0;
    tick();
    check("reset_mid_state", {cmd_ready, busy, id_valid, done}, 4'b1000);
    rst_n       = 1'b1;
    issue_ready = 1'b1;
    repeat (12) tick();
    check("reset_mid_no_done", done_seen, 6);

    exp_beat(5'd10, 2'd0, 12'd0, 8'h1F);
    exp_done(1'b0, 8'd8);
    send(5'd10, 2'd0, 12'd5, 8'h00, 0);
    wait_done(7, "after_reset");

`ifdef VID_SEQ_VSTART_EN
    cmd_vstart = 12'd10;
    exp_beat(5'd4, 2'd0, 12'd8, 8'hFC);
    exp_beat(5'd5, 2'd0, 12'd16, 8'h0F);
    exp_done(1'b0, 8'd9);
    send(5'd3, 2'd0, 12'd20, 8'h00, 0);
    wait_done(8, "vstart10");

    cmd_vstart = 12'd20;
    exp_done(1'b0, 8'd2);
    send(5'd3, 2'd0, 12'd20, 8'h00, 0);
    wait_done(9, "vstart_ge_vl");
    cmd_vstart = '0;
`endif

    repeat (3) tick();
    check("beats_left", beat_exp.size(), 0);
    check("dones_left", done_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vid_seq.md
Name: vid_seq

Overview:
- Command sequencer for the vector index-generation (vid.v) pipeline.
- Accepts one vid.v command: destination register address, SEW and vl.
- Issues it as one or more DATA_WIDTH-wide beats into the index-generation datapath, with per-beat address, start index and tail byte-enable.
- Counts returning results to report completion to the vector issue stage.

Parameters:
REQ_DATA_WIDTH, 64, beat width in bits (multiple of 64)
REQ_BYTE_EN_WIDTH, 8, REQ_DATA_WIDTH/8
REQ_ADDR_WIDTH, 5, register-chunk address width
VL_WIDTH, 12, width of vl and start index
NUM_STAGES, 6, latency of downstream index pipeline (issue to result)
ENABLE_64_BIT, 1, 0 = SEW=64 commands are illegal

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command (state IDLE)
cmd_addr  in  REQ_ADDR_WIDTH  destination base address
cmd_sew  in  2  00=8b, 01=16b, 10=32b, 11=64b
cmd_vl  in  VL_WIDTH  element count
issue_ready  in  1  downstream may take a beat this cycle
id_valid  out  1  beat valid
id_addr  out  REQ_ADDR_WIDTH  beat destination address
id_sew  out  2  latched SEW
id_start_idx  out  VL_WIDTH  first element index of beat
id_be  out  REQ_BYTE_EN_WIDTH  byte-enable of beat (tail masking)
resp_valid  in  1  result emerging from index pipeline
busy  out  1  command in flight (state != IDLE)
done  out  1  one-cycle pulse, command complete
err  out  1  valid with done, command illegal

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0 except cmd_ready=1. Counters cleared. Reset mid-command abandons it; no done pulse.
- Definitions:
  - epb = REQ_BYTE_EN_WIDTH >> sew (elements per beat).
  - beats = ceil(vl/epb), computed by shift/mask only, no divider.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch addr, sew, vl; clear beat counter and outstanding counter.
  - vl==0, or sew==11 with ENABLE_64_BIT==0: go to DONE with no beats (err=1 for the SEW case only).
  - Otherwise go to ISSUE.
- State ISSUE:
  - id_valid=1, combinational from registered state.
  - Beat k fields:
    - id_addr = base+k, modulo 2^REQ_ADDR_WIDTH (wraps).
    - id_start_idx = k*epb (+vstart offset, see optional feature), truncated to VL_WIDTH.
    - id_be = all ones, except the last beat, which enables only the bytes of elements < vl.
  - A beat transfers when id_valid && issue_ready; beat counter advances; outstanding count +1.
  - Holding issue_ready=0 holds all id_* outputs stable.
  - After the final beat transfers, go to DRAIN.
- State DRAIN:
  - id_valid=0.
  - resp_valid decrements outstanding; simultaneous issue and resp_valid leave the count unchanged.
  - When outstanding==0 with no transfer pending, go to DONE.
  - resp_valid while outstanding==0 is ignored (no underflow).
- State DONE:
  - done=1 for exactly one cycle; err as latched; then IDLE.
  - New commands are accepted only in IDLE, so back-to-back commands have at least one idle cycle between them.
- Outstanding counter width is clog2(NUM_STAGES+1)+1; it saturates, never wraps.
- Minimum command latency: accept → DONE = beats + NUM_STAGES + 1 cycles with issue_ready held 1.

Optional Feature:
- VID_SEQ_VSTART_EN defined:
  - Adds input cmd_vstart [VL_WIDTH], latched with the command.
  - Issuing starts at beat floor(vstart/epb).
  - Bytes of that first beat for elements < vstart have id_be=0.
  - id_start_idx is computed as the absolute element index.
  - vstart >= vl: no beats, immediate DONE, err=0.
- Undefined: no port; vstart is treated as 0.

Test Plan:
- sew=00, vl=20, addr=3, issue_ready=1 → 3 beats: addr 3,4,5; start_idx 0,8,16; be FF,FF,0F; done exactly 1+3+6 cycles after accept.
- sew=10, vl=4, issue_ready toggled 1,0,0,1 → 2 beats; id_* held stable during stall; start_idx 0,2; be FF,FF; single done pulse.
- vl=0 → no id_valid; done=1, err=0 two cycles after accept. ENABLE_64_BIT=0 with sew=11, vl=8 → no beats; done=1 with err=1.
- addr=30, sew=01, vl=12 → addrs 30,31,0; last be=FF; verifies address wrap.
- Reset asserted during ISSUE after beat 1 → next cycle state IDLE, cmd_ready=1, busy=0, no done pulse. A new command then completes normally.
- VID_SEQ_VSTART_EN defined, sew=00, vl=20, vstart=10 → beats start at beat 1: start_idx 8,16; be FC,0F.
